// File: rtl/fetch_pkg.sv
// Shared types and default sizing for the instruction fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

    localparam int          DEF_ADDR_W   = 16;
    localparam int          DEF_INSTR_W  = 16;
    localparam logic [15:0] DEF_BOOT_VEC = 16'h0000;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
`ifdef FETCH_IRQ_EN
        ,
        ST_IRQ  = 2'd3
`endif
    } fetch_state_t;

endpackage

// File: rtl/pc_register.sv
// Program counter register with synchronous active-low clear and load enable.
// Latency: one cycle from ld to q.
// Backpressure: holds its value whenever ld is low.
module pc_register #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ld,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: boot-vector load, sequential fetch, branch redirect, halt; FETCH_IRQ_EN adds an interrupt entry.
// Latency: combinational memory read, instruction presented to IF/ID in the same cycle as its address.
// Backpressure: STALL freezes the PC and IF/ID; a taken branch overrides STALL.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                INSTR_W  = DEF_INSTR_W,
    parameter logic [ADDR_W-1:0] BOOT_VEC = ADDR_W'(DEF_BOOT_VEC)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               STALL,
    input  logic               BR_TAKEN,
    input  logic [ADDR_W-1:0]  BR_TARGET,
    input  logic               HALT_REQ,
    output logic [ADDR_W-1:0]  IMEM_ADDR,
    input  logic [INSTR_W-1:0] IMEM_DATA,
    output logic [INSTR_W-1:0] INSTR_OUT,
    output logic [ADDR_W-1:0]  PC_OUT,
    output logic               IFID_EN,
    output logic               FLUSH
`ifdef FETCH_IRQ_EN
    ,
    input  logic               IRQ,
    input  logic [ADDR_W-1:0]  IRQ_VEC_ADDR,
    output logic               IRQ_ACK,
    output logic [ADDR_W-1:0]  SAVED_PC
`endif
);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] mem_pc;
    logic              pc_ld;
    logic              irq_take;

    assign pc_inc = pc_q + ADDR_W'(1);
    assign mem_pc = ADDR_W'(IMEM_DATA);

`ifdef FETCH_IRQ_EN
    logic pending;

    // A request arriving this cycle is serviceable immediately, so the return PC is the one it arrived at.
    assign irq_take = (pending | IRQ) &&
                      (((state == ST_RUN) && !STALL && !BR_TAKEN) || (state == ST_HALT));
`else
    assign irq_take = 1'b0;
`endif

    pc_register #(
        .W(ADDR_W)
    ) u_pc (
        .clk  (CLK),
        .rst_n(RST),
        .ld   (pc_ld),
        .d    (pc_d),
        .q    (pc_q)
    );

    always_comb begin
        IMEM_ADDR = pc_q;
        INSTR_OUT = '0;
        PC_OUT    = '0;
        IFID_EN   = 1'b0;
        FLUSH     = 1'b0;
        pc_ld     = 1'b0;
        pc_d      = pc_inc;
`ifdef FETCH_IRQ_EN
        IRQ_ACK   = 1'b0;
`endif
        case (state)
            ST_BOOT: begin
                IMEM_ADDR = BOOT_VEC;
                pc_ld     = 1'b1;
                pc_d      = mem_pc;
            end
            ST_RUN: begin
                INSTR_OUT = IMEM_DATA;
                PC_OUT    = pc_inc;
                IFID_EN   = !STALL;
                if (BR_TAKEN) begin
                    FLUSH = 1'b1;
                    pc_ld = 1'b1;
                    pc_d  = BR_TARGET;
                end else if (!irq_take && !HALT_REQ && !STALL) begin
                    pc_ld = 1'b1;
                end
            end
            ST_HALT: begin
                FLUSH = 1'b1;
            end
`ifdef FETCH_IRQ_EN
            ST_IRQ: begin
                IMEM_ADDR = IRQ_VEC_ADDR;
                FLUSH     = 1'b1;
                IRQ_ACK   = 1'b1;
                pc_ld     = 1'b1;
                pc_d      = mem_pc;
            end
`endif
            default: begin
                pc_ld = 1'b0;
            end
        endcase
        // Downstream sees a quiet stage for the whole reset cycle, whatever state we were in.
        if (!RST) begin
            INSTR_OUT = '0;
            PC_OUT    = '0;
            IFID_EN   = 1'b0;
            FLUSH     = 1'b0;
`ifdef FETCH_IRQ_EN
            IRQ_ACK   = 1'b0;
`endif
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state    <= ST_BOOT;
`ifdef FETCH_IRQ_EN
            pending  <= 1'b0;
            SAVED_PC <= '0;
`endif
        end else begin
            case (state)
                ST_BOOT: state <= ST_RUN;
                ST_RUN: begin
                    if (BR_TAKEN) begin
                        state <= ST_RUN;
`ifdef FETCH_IRQ_EN
                    end else if (irq_take) begin
                        state <= ST_IRQ;
`endif
                    end else if (HALT_REQ) begin
                        state <= ST_HALT;
                    end
                end
                ST_HALT: begin
`ifdef FETCH_IRQ_EN
                    if (irq_take) begin
                        state <= ST_IRQ;
                    end
`else
                    state <= ST_HALT;
`endif
                end
`ifdef FETCH_IRQ_EN
                ST_IRQ: begin
                    state    <= ST_RUN;
                    SAVED_PC <= pc_q;
                end
`endif
                default: state <= ST_BOOT;
            endcase
`ifdef FETCH_IRQ_EN
            pending <= IRQ | (pending && (state != ST_IRQ));
`endif
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a cycle-level reference model and per-cycle output compare.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        STALL = 1'b0;
    logic        BR_TAKEN = 1'b0;
    logic [15:0] BR_TARGET = 16'h0000;
    logic        HALT_REQ = 1'b0;
    logic [15:0] IMEM_ADDR;
    logic [15:0] IMEM_DATA;
    logic [15:0] INSTR_OUT;
    logic [15:0] PC_OUT;
    logic        IFID_EN;
    logic        FLUSH;
`ifdef FETCH_IRQ_EN
    logic        IRQ = 1'b0;
    logic [15:0] IRQ_VEC_ADDR = 16'h0001;
    logic        IRQ_ACK;
    logic [15:0] SAVED_PC;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] mem [0:65535];
    assign IMEM_DATA = mem[IMEM_ADDR];

    always #5 CLK = ~CLK;

    fetch_unit dut (
        .CLK         (CLK),
        .RST         (RST),
        .STALL       (STALL),
        .BR_TAKEN    (BR_TAKEN),
        .BR_TARGET   (BR_TARGET),
        .HALT_REQ    (HALT_REQ),
        .IMEM_ADDR   (IMEM_ADDR),
        .IMEM_DATA   (IMEM_DATA),
        .INSTR_OUT   (INSTR_OUT),
        .PC_OUT      (PC_OUT),
        .IFID_EN     (IFID_EN),
        .FLUSH       (FLUSH)
`ifdef FETCH_IRQ_EN
        ,
        .IRQ         (IRQ),
        .IRQ_VEC_ADDR(IRQ_VEC_ADDR),
        .IRQ_ACK     (IRQ_ACK),
        .SAVED_PC    (SAVED_PC)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: what the fetch stage is doing, tracked as plain flags and a PC.
    bit          m_booted = 1'b0;
    bit          m_halted = 1'b0;
    bit          m_inirq = 1'b0;
    bit          m_pend = 1'b0;
    bit          m_saved_ok = 1'b0;
    logic [15:0] m_pc = 16'h0000;
    logic [15:0] m_saved = 16'h0000;
    logic        irq_now;

`ifdef FETCH_IRQ_EN
    assign irq_now = m_pend | IRQ;
`else
    assign irq_now = 1'b0;
`endif

    always @(posedge CLK) begin
        if (!RST) begin
            m_booted   <= 1'b0;
            m_halted   <= 1'b0;
            m_inirq    <= 1'b0;
            m_pend     <= 1'b0;
            m_saved_ok <= 1'b0;
            m_pc       <= 16'h0000;
        end else if (!m_booted) begin
            m_pc     <= mem[16'h0000];
            m_booted <= 1'b1;
            m_pend   <= irq_now;
`ifdef FETCH_IRQ_EN
        end else if (m_inirq) begin
            m_saved    <= m_pc;
            m_saved_ok <= 1'b1;
            m_pc       <= mem[IRQ_VEC_ADDR];
            m_inirq    <= 1'b0;
            m_pend     <= IRQ;
`endif
        end else if (m_halted) begin
            m_pend <= irq_now;
            if (irq_now) begin
                m_halted <= 1'b0;
                m_inirq  <= 1'b1;
            end
        end else begin
            m_pend <= irq_now;
            if (BR_TAKEN)
                m_pc <= BR_TARGET;
            else if (irq_now && !STALL)
                m_inirq <= 1'b1;
            else if (HALT_REQ)
                m_halted <= 1'b1;
            else if (!STALL)
                m_pc <= m_pc + 16'd1;
        end
    end

    always @(negedge CLK) begin
        if (!RST) begin
            chk("rst_instr", INSTR_OUT, 0);
            chk("rst_pcout", PC_OUT, 0);
            chk("rst_ifid", IFID_EN, 0);
            chk("rst_flush", FLUSH, 0);
`ifdef FETCH_IRQ_EN
            chk("rst_ack", IRQ_ACK, 0);
`endif
        end else if (!m_booted) begin
            chk("boot_addr", IMEM_ADDR, 16'h0000);
            chk("boot_ifid", IFID_EN, 0);
            chk("boot_flush", FLUSH, 0);
`ifdef FETCH_IRQ_EN
        end else if (m_inirq) begin
            chk("irq_addr", IMEM_ADDR, IRQ_VEC_ADDR);
            chk("irq_ack", IRQ_ACK, 1);
            chk("irq_flush", FLUSH, 1);
            chk("irq_ifid", IFID_EN, 0);
`endif
        end else if (m_halted) begin
            chk("halt_addr", IMEM_ADDR, m_pc);
            chk("halt_ifid", IFID_EN, 0);
            chk("halt_flush", FLUSH, 1);
        end else begin
            chk("run_addr", IMEM_ADDR, m_pc);
            chk("run_instr", INSTR_OUT, mem[m_pc]);
            chk("run_pcout", PC_OUT, 16'(m_pc + 16'd1));
            chk("run_ifid", IFID_EN, !STALL);
            chk("run_flush", FLUSH, BR_TAKEN);
`ifdef FETCH_IRQ_EN
            chk("run_ack", IRQ_ACK, 0);
`endif
        end
`ifdef FETCH_IRQ_EN
        if (RST && m_saved_ok)
            chk("saved_pc", SAVED_PC, m_saved);
`endif
    end

    // Inputs change 1 time unit after the rising edge; literal checks land 3 units later.
    task automatic go(input bit rst, input bit stl, input bit br, input logic [15:0] tgt,
                      input bit hlt, input bit irq);
        @(posedge CLK);
        #1;
        RST       = rst;
        STALL     = stl;
        BR_TAKEN  = br;
        BR_TARGET = tgt;
        HALT_REQ  = hlt;
`ifdef FETCH_IRQ_EN
        IRQ       = irq;
`else
        if (irq) BR_TARGET = tgt;
`endif
        #3;
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 16'(a) ^ 16'h5A00;
        mem[0] = 16'h0040;
        mem[1] = 16'h0200;

        repeat (2) go(0, 0, 0, 16'h0, 0, 0);
        chk("lit_rst_ifid", IFID_EN, 0);
        chk("lit_rst_pcout", PC_OUT, 0);

        // boot
        go(1, 0, 0, 16'h0, 0, 0);
        chk("lit_boot_addr", IMEM_ADDR, 16'h0000);
        go(1, 0, 0, 16'h0, 0, 0);
        chk("lit_f0_addr", IMEM_ADDR, 16'h0040);
        chk("lit_f0_pcout", PC_OUT, 16'h0041);
        go(1, 0, 0, 16'h0, 0, 0);
        chk("lit_f1_addr", IMEM_ADDR, 16'h0041);
        chk("lit_f1_pcout", PC_OUT, 16'h0042);
        go(1, 0, 0, 16'h0, 0, 0);
        chk("lit_f2_addr", IMEM_ADDR, 16'h0042);
        chk("lit_f2_pcout", PC_OUT, 16'h0043);
        repeat (2) go(1, 0, 0, 16'h0, 0, 0);

        // stall at 0045
        for (int i = 0; i < 3; i++) begin
            go(1, 1, 0, 16'h0, 0, 0);
            chk("lit_stall_addr", IMEM_ADDR, 16'h0045);
            chk("lit_stall_ifid", IFID_EN, 0);
        end
        go(1, 0, 0, 16'h0, 0, 0);
        chk("lit_unstall_ifid", IFID_EN, 1);

        // branch together with stall
        go(1, 1, 1, 16'h0100, 0, 0);
        chk("lit_brst_addr", IMEM_ADDR, 16'h0046);
        chk("lit_brst_flush", FLUSH, 1);
        go(1, 0, 0, 16'h0, 0, 0);
        chk("lit_br_dest", IMEM_ADDR, 16'h0100);
        chk("lit_br_flush0", FLUSH, 0);

        // wrap, then branch beating halt, then halt
        go(1, 0, 1, 16'hFFFF, 0, 0);
        go(1, 0, 0, 16'h0, 0, 0);
        chk("lit_wrap_addr", IMEM_ADDR, 16'hFFFF);
        chk("lit_wrap_pcout", PC_OUT, 16'h0000);
        go(1, 0, 1, 16'h0010, 1, 0);
        chk("lit_wrap_next", IMEM_ADDR, 16'h0000);
        chk("lit_brhalt_flush", FLUSH, 1);
        go(1, 0, 0, 16'h0, 1, 0);
        chk("lit_brhalt_dest", IMEM_ADDR, 16'h0010);
        chk("lit_brhalt_ifid", IFID_EN, 1);
        for (int i = 0; i < 4; i++) begin
            go(1, 0, i[0], 16'h0300, 0, 0);
            chk("lit_halt_addr", IMEM_ADDR, 16'h0010);
            chk("lit_halt_ifid", IFID_EN, 0);
            chk("lit_halt_flush", FLUSH, 1);
        end

        // reset out of halt, then reset during a branch
        go(0, 0, 0, 16'h0, 0, 0);
        go(1, 0, 0, 16'h0, 0, 0);
        chk("lit_reboot_addr", IMEM_ADDR, 16'h0000);
        go(1, 0, 0, 16'h0, 0, 0);
        go(0, 0, 1, 16'h0080, 0, 0);
        chk("lit_rstbr_flush", FLUSH, 0);
        chk("lit_rstbr_instr", INSTR_OUT, 0);
        go(1, 0, 0, 16'h0, 0, 0);
        chk("lit_rstbr_boot", IMEM_ADDR, 16'h0000);
        go(1, 0, 0, 16'h0, 0, 0);
        chk("lit_rstbr_f0", IMEM_ADDR, 16'h0040);

`ifdef FETCH_IRQ_EN
        // interrupt at 0050
        go(1, 0, 1, 16'h0050, 0, 0);
        go(1, 0, 0, 16'h0, 0, 1);
        chk("lit_irq_at", IMEM_ADDR, 16'h0050);
        go(1, 0, 0, 16'h0, 0, 0);
        chk("lit_irq_vec", IMEM_ADDR, 16'h0001);
        chk("lit_irq_ack", IRQ_ACK, 1);
        chk("lit_irq_flush", FLUSH, 1);
        go(1, 0, 0, 16'h0, 0, 0);
        chk("lit_irq_dest", IMEM_ADDR, 16'h0200);
        chk("lit_irq_ack0", IRQ_ACK, 0);
        chk("lit_irq_saved", SAVED_PC, 16'h0050);

        // request held pending across a stall
        go(1, 1, 0, 16'h0, 0, 1);
        go(1, 1, 0, 16'h0, 0, 0);
        chk("lit_pend_ack0", IRQ_ACK, 0);
        go(1, 0, 0, 16'h0, 0, 0);
        go(1, 0, 0, 16'h0, 0, 0);
        chk("lit_pend_ack", IRQ_ACK, 1);
        go(1, 0, 0, 16'h0, 0, 0);
        chk("lit_pend_saved", SAVED_PC, 16'h0201);

        // reset during the interrupt cycle
        go(1, 0, 0, 16'h0, 0, 1);
        go(0, 0, 0, 16'h0, 0, 0);
        chk("lit_rstirq_ack", IRQ_ACK, 0);
        chk("lit_rstirq_flush", FLUSH, 0);
        go(1, 0, 0, 16'h0, 0, 0);
        chk("lit_rstirq_boot", IMEM_ADDR, 16'h0000);
        repeat (3) begin
            go(1, 0, 0, 16'h0, 0, 0);
            chk("lit_rstirq_noack", IRQ_ACK, 0);
        end
`endif

        repeat (2) go(1, 0, 0, 16'h0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
